// File: rtl/ccip_txn_scoreboard.sv
// ccip_txn_scoreboard: passive CCI-P monitor matching requests to responses by mdata tag,
// reporting latency and dup/orphan/timeout errors through registered strobes.
package ccip_txn_pkg;
  typedef struct packed {
    logic [1:0]  vcSel;
    logic [1:0]  clLen;
    logic [3:0]  reqType;
    logic [41:0] address;
    logic [15:0] mdata;
  } TxHdr_t;
  typedef struct packed {
    logic [1:0]  vcUsed;
    logic        hitMiss;
    logic [1:0]  clNum;
    logic [3:0]  respType;
    logic [15:0] mdata;
  } RxHdr_t;
  localparam logic [3:0] eREQ_RDLINE_I = 4'h0;
  localparam logic [3:0] eREQ_RDLINE_S = 4'h1;
  localparam logic [3:0] eREQ_WRLINE_I = 4'h0;
  localparam logic [3:0] eREQ_WRLINE_M = 4'h1;
  localparam logic [3:0] eREQ_WRFENCE  = 4'h4;
  localparam logic [3:0] eREQ_INTR     = 4'h6;
endpackage

module ccip_txn_sb_table #(
  parameter int TAG_BITS       = 6,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 SoftReset_n,
  input  logic [CNT_WIDTH-1:0] now,
  input  logic [TAG_BITS-1:0]  scanPtr,
  input  logic                 iss,
  input  logic [TAG_BITS-1:0]  issTag,
  input  logic                 rspA,
  input  logic [TAG_BITS-1:0]  tagA,
  input  logic                 rspB,
  input  logic [TAG_BITS-1:0]  tagB,
  output logic [TAG_BITS:0]    outstanding,
  output logic                 hitA,
  output logic                 hitB,
  output logic                 orphA,
  output logic                 orphB,
  output logic                 dup,
  output logic                 tmo,
  output logic [CNT_WIDTH-1:0] latA,
  output logic [CNT_WIDTH-1:0] latB
);
  localparam int DEPTH = 1 << TAG_BITS;
  logic [DEPTH-1:0] busy, busyNext, timedOut, toNext;
  logic [CNT_WIDTH-1:0] ts [DEPTH];
  logic [CNT_WIDTH-1:0] age;
  // Responses are applied before the issue, so a same-tag issue sees the post-response state.
  always_comb begin
    hitA = rspA && busy[tagA];
    orphA = rspA && !busy[tagA];
    hitB = rspB && busy[tagB] && !(hitA && tagA == tagB);
    orphB = rspB && !hitB;
    busyNext = busy;
    if (hitA) busyNext[tagA] = 1'b0;
    if (hitB) busyNext[tagB] = 1'b0;
    dup = iss && busyNext[issTag];
    if (iss) busyNext[issTag] = 1'b1;
    age = now - ts[scanPtr];
    tmo = busy[scanPtr] && !timedOut[scanPtr] && age >= CNT_WIDTH'(TIMEOUT_CYCLES) &&
          !(rspA && tagA == scanPtr) && !(rspB && tagB == scanPtr) && !(iss && issTag == scanPtr);
    toNext = timedOut;
    if (iss) toNext[issTag] = 1'b0;
    if (tmo) toNext[scanPtr] = 1'b1;
    latA = now - ts[tagA];
    latB = now - ts[tagB];
  end
  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      busy <= '0;
      timedOut <= '0;
      outstanding <= '0;
    end else begin
      busy <= busyNext;
      timedOut <= toNext;
      outstanding <= outstanding + (TAG_BITS+1)'(iss && !dup) - (TAG_BITS+1)'(hitA) - (TAG_BITS+1)'(hitB);
    end
  end
  always_ff @(posedge clk) begin
    if (iss) ts[issTag] <= now;
  end
endmodule

module ccip_txn_scoreboard
  import ccip_txn_pkg::*;
#(
  parameter int TAG_BITS       = 6,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 SoftReset_n,
  input  TxHdr_t               C0TxHdr,
  input  logic                 C0TxRdValid,
  input  TxHdr_t               C1TxHdr,
  input  logic                 C1TxWrValid,
  input  RxHdr_t               C0RxHdr,
  input  logic                 C0RxRdValid,
  input  logic                 C0RxWrValid,
  input  RxHdr_t               C1RxHdr,
  input  logic                 C1RxWrValid,
  output logic [TAG_BITS:0]    rd_outstanding,
  output logic [TAG_BITS:0]    wr_outstanding,
  output logic                 idle,
  output logic                 lat_valid,
  output logic                 lat_is_write,
  output logic [TAG_BITS-1:0]  lat_tag,
  output logic [CNT_WIDTH-1:0] lat_value,
  output logic                 err_valid,
  output logic [1:0]           err_code,
  output logic                 err_is_write,
  output logic [TAG_BITS-1:0]  err_tag,
  output logic [5:0]           err_sticky
);
  logic [CNT_WIDTH-1:0] now, rdLat, rdLatB, wrLatA, wrLatB, latVal;
  logic [TAG_BITS-1:0] scanPtr, rdIssTag, rdRspTag, wrIssTag, wrTagA, wrTagB, latT, errT;
  logic rdIss, wrIss, rdHit, rdHitB, rdOrph, rdOrphB, rdDup, rdTmo;
  logic wrHitA, wrHitB, wrOrphA, wrOrphB, wrDup, wrTmo, latV, latW, errW;
  logic [1:0] errC;
  logic [5:0] errs;
  logic unusedBits;
  assign rdIss = C0TxRdValid && (C0TxHdr.reqType == eREQ_RDLINE_I || C0TxHdr.reqType == eREQ_RDLINE_S);
  assign wrIss = C1TxWrValid && (C1TxHdr.reqType == eREQ_WRLINE_I || C1TxHdr.reqType == eREQ_WRLINE_M);
  assign rdIssTag = C0TxHdr.mdata[TAG_BITS-1:0];
  assign wrIssTag = C1TxHdr.mdata[TAG_BITS-1:0];
  assign rdRspTag = C0RxHdr.mdata[TAG_BITS-1:0];
  assign wrTagA = C0RxHdr.mdata[TAG_BITS-1:0];
  assign wrTagB = C1RxHdr.mdata[TAG_BITS-1:0];
  assign idle = rd_outstanding == '0 && wr_outstanding == '0;
  assign unusedBits = ^{C0TxHdr, C1TxHdr, C0RxHdr, C1RxHdr, rdHitB, rdOrphB, rdLatB};
  ccip_txn_sb_table #(.TAG_BITS(TAG_BITS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_WIDTH(CNT_WIDTH)) rdTab (
    .clk(clk), .SoftReset_n(SoftReset_n), .now(now), .scanPtr(scanPtr),
    .iss(rdIss), .issTag(rdIssTag), .rspA(C0RxRdValid), .tagA(rdRspTag), .rspB(1'b0), .tagB('0),
    .outstanding(rd_outstanding), .hitA(rdHit), .hitB(rdHitB), .orphA(rdOrph), .orphB(rdOrphB),
    .dup(rdDup), .tmo(rdTmo), .latA(rdLat), .latB(rdLatB));
  ccip_txn_sb_table #(.TAG_BITS(TAG_BITS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_WIDTH(CNT_WIDTH)) wrTab (
    .clk(clk), .SoftReset_n(SoftReset_n), .now(now), .scanPtr(scanPtr),
    .iss(wrIss), .issTag(wrIssTag), .rspA(C0RxWrValid), .tagA(wrTagA), .rspB(C1RxWrValid), .tagB(wrTagB),
    .outstanding(wr_outstanding), .hitA(wrHitA), .hitB(wrHitB), .orphA(wrOrphA), .orphB(wrOrphB),
    .dup(wrDup), .tmo(wrTmo), .latA(wrLatA), .latB(wrLatB));
  // One reporter per strobe: read table first, then write; dup > orphan > timeout.
  always_comb begin
    latV = rdHit || wrHitA || wrHitB;
    latW = !rdHit && (wrHitA || wrHitB);
    latT = rdHit ? rdRspTag : wrHitA ? wrTagA : wrHitB ? wrTagB : '0;
    latVal = rdHit ? rdLat : wrHitA ? wrLatA : wrHitB ? wrLatB : '0;
    errs = {wrTmo, wrOrphA || wrOrphB, wrDup, rdTmo, rdOrph, rdDup};
    errW = errs[5:3] != '0 && errs[2:0] == '0;
    errC = (rdDup || (!errs[2] && !errs[1] && wrDup)) ? 2'b01 :
           (rdOrph || (!errs[2] && errs[4])) ? 2'b10 :
           (errs != '0) ? 2'b11 : 2'b00;
    errT = rdDup ? rdIssTag : rdOrph ? rdRspTag : rdTmo ? scanPtr :
           wrDup ? wrIssTag : wrOrphA ? wrTagA : wrOrphB ? wrTagB : wrTmo ? scanPtr : '0;
  end
  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      now <= '0;
      scanPtr <= '0;
      lat_valid <= 1'b0;
      lat_is_write <= 1'b0;
      lat_tag <= '0;
      lat_value <= '0;
      err_valid <= 1'b0;
      err_code <= '0;
      err_is_write <= 1'b0;
      err_tag <= '0;
      err_sticky <= '0;
    end else begin
      now <= now + 1'b1;
      scanPtr <= scanPtr + 1'b1;
      lat_valid <= latV;
      lat_is_write <= latW;
      lat_tag <= latT;
      lat_value <= latVal;
      err_valid <= errs != '0;
      err_code <= errC;
      err_is_write <= errW;
      err_tag <= errT;
      err_sticky <= err_sticky | errs;
    end
  end
endmodule

// File: tb/tb_ccip_txn_scoreboard.sv
// tb_ccip_txn_scoreboard: directed vectors against hand-computed latencies and error codes.
module tb_ccip_txn_scoreboard;
  import ccip_txn_pkg::*;
  localparam int TMO = 140;
  logic clk = 1'b0;
  logic SoftReset_n;
  TxHdr_t c0TxHdr, c1TxHdr;
  RxHdr_t c0RxHdr, c1RxHdr;
  logic c0TxRdValid, c1TxWrValid, c0RxRdValid, c0RxWrValid, c1RxWrValid;
  logic [6:0] rd_outstanding, wr_outstanding;
  logic idle, lat_valid, lat_is_write, err_valid, err_is_write;
  logic [5:0] lat_tag, err_tag, err_sticky;
  logic [31:0] lat_value;
  logic [1:0] err_code;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ccip_txn_scoreboard #(.TAG_BITS(6), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(32)) dut (
    .clk(clk), .SoftReset_n(SoftReset_n),
    .C0TxHdr(c0TxHdr), .C0TxRdValid(c0TxRdValid), .C1TxHdr(c1TxHdr), .C1TxWrValid(c1TxWrValid),
    .C0RxHdr(c0RxHdr), .C0RxRdValid(c0RxRdValid), .C0RxWrValid(c0RxWrValid),
    .C1RxHdr(c1RxHdr), .C1RxWrValid(c1RxWrValid),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding), .idle(idle),
    .lat_valid(lat_valid), .lat_is_write(lat_is_write), .lat_tag(lat_tag), .lat_value(lat_value),
    .err_valid(err_valid), .err_code(err_code), .err_is_write(err_is_write), .err_tag(err_tag),
    .err_sticky(err_sticky));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    c0TxRdValid = 1'b0;
    c1TxWrValid = 1'b0;
    c0RxRdValid = 1'b0;
    c0RxWrValid = 1'b0;
    c1RxWrValid = 1'b0;
  endtask
  task automatic rdReq(input logic [3:0] t, input logic [15:0] m);
    c0TxHdr = '0; c0TxHdr.reqType = t; c0TxHdr.mdata = m; c0TxRdValid = 1'b1;
  endtask
  task automatic wrReq(input logic [3:0] t, input logic [15:0] m);
    c1TxHdr = '0; c1TxHdr.reqType = t; c1TxHdr.mdata = m; c1TxWrValid = 1'b1;
  endtask
  task automatic rdRsp(input logic [15:0] m);
    c0RxHdr = '0; c0RxHdr.mdata = m; c0RxRdValid = 1'b1;
  endtask
  task automatic wrRsp0(input logic [15:0] m);
    c0RxHdr = '0; c0RxHdr.mdata = m; c0RxWrValid = 1'b1;
  endtask
  task automatic wrRsp1(input logic [15:0] m);
    c1RxHdr = '0; c1RxHdr.mdata = m; c1RxWrValid = 1'b1;
  endtask
  initial begin
    int first, nerr, nlat;
    c0TxHdr = '0; c1TxHdr = '0; c0RxHdr = '0; c1RxHdr = '0;
    c0TxRdValid = 0; c1TxWrValid = 0; c0RxRdValid = 0; c0RxWrValid = 0; c1RxWrValid = 0;
    SoftReset_n = 1'b0;
    repeat (3) step();
    chk("rst_rd_out", rd_outstanding, 0);
    chk("rst_wr_out", wr_outstanding, 0);
    chk("rst_idle", idle, 1);
    chk("rst_lat_valid", lat_valid, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_sticky", err_sticky, 0);
    SoftReset_n = 1'b1;
    step();
    // basic read latency, response carries aliasing upper mdata bits
    rdReq(eREQ_RDLINE_I, 16'h0005);
    step();
    chk("rd_out_one", rd_outstanding, 1);
    chk("idle_busy", idle, 0);
    repeat (19) step();
    rdRsp(16'h0105);
    step();
    chk("lat_valid", lat_valid, 1);
    chk("lat_value", lat_value, 20);
    chk("lat_is_write", lat_is_write, 0);
    chk("lat_tag", lat_tag, 5);
    chk("rd_out_zero", rd_outstanding, 0);
    chk("lat_no_err", err_valid, 0);
    step();
    chk("lat_one_shot", lat_valid, 0);
    // write duplicate
    wrReq(eREQ_WRLINE_I, 16'd3);
    step();
    wrReq(eREQ_WRLINE_M, 16'd3);
    step();
    chk("dup_valid", err_valid, 1);
    chk("dup_code", err_code, 1);
    chk("dup_is_write", err_is_write, 1);
    chk("dup_tag", err_tag, 3);
    chk("dup_wr_out", wr_outstanding, 1);
    chk("dup_sticky", err_sticky, 6'b001000);
    wrRsp1(16'd3);
    step();
    chk("wr_lat_valid", lat_valid, 1);
    chk("wr_lat_is_write", lat_is_write, 1);
    chk("wr_lat_value", lat_value, 1);
    chk("wr_out_zero", wr_outstanding, 0);
    wrReq(eREQ_WRFENCE, 16'd4);
    step();
    chk("fence_wr_out", wr_outstanding, 0);
    chk("fence_no_err", err_valid, 0);
    // orphan read response
    rdRsp(16'h0409);
    step();
    chk("orph_valid", err_valid, 1);
    chk("orph_code", err_code, 2);
    chk("orph_tag", err_tag, 9);
    chk("orph_is_write", err_is_write, 0);
    chk("orph_rd_out", rd_outstanding, 0);
    chk("orph_sticky", err_sticky, 6'b001010);
    // timeout, then late completion
    rdReq(eREQ_RDLINE_S, 16'd2);
    step();
    first = -1;
    nerr = 0;
    for (int i = 1; i < 300; i++) begin
      step();
      if (err_valid) begin
        nerr++;
        if (first < 0) first = i;
        chk("tmo_code", err_code, 3);
        chk("tmo_tag", err_tag, 2);
      end
    end
    rdRsp(16'd2);
    step();
    chk("tmo_count", nerr, 1);
    chk("tmo_window", (first >= TMO && first <= TMO + 64), 1);
    chk("late_lat_valid", lat_valid, 1);
    chk("late_lat_value", lat_value, 300);
    chk("late_no_err", err_valid, 0);
    chk("tmo_sticky", err_sticky, 6'b001110);
    chk("late_rd_out", rd_outstanding, 0);
    // fill all tags, drain in reverse
    nerr = 0;
    nlat = 0;
    for (int t = 0; t < 64; t++) begin
      rdReq(eREQ_RDLINE_I, 16'(t));
      step();
      if (err_valid) nerr++;
      if (lat_valid) nlat++;
    end
    chk("fill_rd_out", rd_outstanding, 64);
    chk("fill_idle", idle, 0);
    for (int t = 63; t >= 0; t--) begin
      rdRsp(16'(t));
      step();
      if (err_valid) nerr++;
      if (lat_valid) nlat++;
      chk("drain_tag", lat_tag, t);
      chk("drain_lat", lat_value, 127 - 2 * t);
    end
    chk("drain_lat_count", nlat, 64);
    chk("drain_err_count", nerr, 0);
    chk("drain_rd_out", rd_outstanding, 0);
    chk("drain_idle", idle, 1);
    // two write responses to one tag in one cycle
    wrReq(eREQ_WRLINE_I, 16'd10);
    step();
    wrRsp0(16'd10);
    wrRsp1(16'd10);
    step();
    chk("dual_lat_valid", lat_valid, 1);
    chk("dual_lat_tag", lat_tag, 10);
    chk("dual_lat_value", lat_value, 1);
    chk("dual_err_code", err_code, 2);
    chk("dual_err_is_write", err_is_write, 1);
    chk("dual_err_tag", err_tag, 10);
    chk("dual_wr_out", wr_outstanding, 0);
    chk("dual_sticky", err_sticky, 6'b011110);
    // same-cycle response and re-issue, then reset mid-flight
    rdReq(eREQ_RDLINE_I, 16'd7);
    step();
    repeat (5) step();
    rdRsp(16'd7);
    rdReq(eREQ_RDLINE_S, 16'd7);
    step();
    chk("reissue_lat_valid", lat_valid, 1);
    chk("reissue_lat_value", lat_value, 6);
    chk("reissue_lat_tag", lat_tag, 7);
    chk("reissue_rd_out", rd_outstanding, 1);
    chk("reissue_no_err", err_valid, 0);
    #2 SoftReset_n = 1'b0;
    #1;
    chk("async_rd_out", rd_outstanding, 0);
    chk("async_idle", idle, 1);
    chk("async_sticky", err_sticky, 0);
    step();
    SoftReset_n = 1'b1;
    rdRsp(16'd7);
    step();
    chk("post_rst_orph", err_valid, 1);
    chk("post_rst_code", err_code, 2);
    chk("post_rst_tag", err_tag, 7);
    chk("post_rst_sticky", err_sticky, 6'b000010);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
